// File: rtl/cart_bus_drv.sv
// Cartridge data-bus driver: fixed-priority source mux plus transceiver dir/oe sequencing.
// Optional collision counter enabled with `define CART_BUS_COLL_EN.
module cart_bus_drv #(
  parameter int              CHANNELS  = 8,
  parameter int              DW        = 16,
  parameter int              DIR_SETUP = 2,
  parameter int              REL_HOLD  = 1,
  parameter logic [DW-1:0]   IDLE_DATA = 16'h0000
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic [CHANNELS-1:0]          src_oe,
  input  logic [CHANNELS*DW-1:0]       src_do,
  output logic [DW-1:0]                bus_do,
  output logic                         dat_dir,
  output logic                         dat_oe,
  output logic                         busy,
  output logic [$clog2(CHANNELS)-1:0]  active_ch,
  output logic                         coll_flag,
  output logic [15:0]                  coll_cnt
);

  localparam int CW = $clog2(CHANNELS);
  localparam logic [3:0] SETUP_LD = 4'(DIR_SETUP - 1);
  localparam logic [3:0] REL_LD   = 4'(REL_HOLD);

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DW-1:0]     bus_do_q, bus_do_d;
  logic [CW-1:0]     active_ch_q, active_ch_d;
  logic              any_oe;
  logic [CW-1:0]     grant;
  logic [DW-1:0]     grant_data;

  assign any_oe = |src_oe;

  // Descending scan so the lowest requesting index wins.
  always_comb begin
    grant      = '0;
    grant_data = IDLE_DATA;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (src_oe[i]) begin
        grant      = CW'(i);
        grant_data = src_do[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_do_q    <= IDLE_DATA;
      active_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_do_q    <= bus_do_d;
      active_ch_q <= active_ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_oe) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (!any_oe) begin
          state_d = RELEASE;
          cnt_d   = REL_LD;
        end else if (cnt_q == 4'd0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRIVE: begin
        if (!any_oe) begin
          state_d = RELEASE;
          cnt_d   = REL_LD;
        end
      end
      RELEASE: begin
        // Direction is already outward, so a new request re-enables without setup.
        if (any_oe) begin
          state_d = DRIVE;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dat_dir = (state_q != IDLE);
    dat_oe  = (state_q != DRIVE);
    busy    = (state_q != IDLE);
  end

  always_comb begin
    bus_do_d    = bus_do_q;
    active_ch_d = active_ch_q;
    if (any_oe) begin
      bus_do_d    = grant_data;
      active_ch_d = grant;
    end else if (state_q == IDLE) begin
      bus_do_d = IDLE_DATA;
    end
  end

  assign bus_do    = bus_do_q;
  assign active_ch = active_ch_q;

`ifdef CART_BUS_COLL_EN
  logic [CHANNELS-1:0] prev_oe_q, prev_oe_d;
  logic                coll_flag_q, coll_flag_d;
  logic [15:0]         coll_cnt_q, coll_cnt_d;
  logic                multi_oe;

  // A new overlap pattern while driving counts once; a held overlap does not.
  always_comb begin
    multi_oe    = (src_oe & (src_oe - CHANNELS'(1))) != '0;
    prev_oe_d   = src_oe;
    coll_flag_d = (state_q == DRIVE) && multi_oe && (src_oe != prev_oe_q);
    coll_cnt_d  = coll_cnt_q;
    if (coll_flag_d && (coll_cnt_q != 16'hFFFF)) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_oe_q   <= '0;
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      prev_oe_q   <= prev_oe_d;
      coll_flag_q <= coll_flag_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign coll_flag = coll_flag_q;
  assign coll_cnt  = coll_cnt_q;
`else
  assign coll_flag = 1'b0;
  assign coll_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_cart_bus_drv.sv
// Bench for cart_bus_drv: cycle model of the dir/oe timing rules plus directed scenarios.
module tb_cart_bus_drv;

  localparam int            CHANNELS  = 8;
  localparam int            DW        = 16;
  localparam int            DIR_SETUP = 2;
  localparam int            REL_HOLD  = 1;
  localparam logic [DW-1:0] IDLE_DATA = 16'h0000;
  localparam int            CW        = $clog2(CHANNELS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CHANNELS-1:0]    src_oe;
  logic [CHANNELS*DW-1:0] src_do;
  logic [DW-1:0]          bus_do;
  logic                   dat_dir, dat_oe, busy, coll_flag;
  logic [CW-1:0]          active_ch;
  logic [15:0]            coll_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  cart_bus_drv #(
    .CHANNELS(CHANNELS), .DW(DW), .DIR_SETUP(DIR_SETUP),
    .REL_HOLD(REL_HOLD), .IDLE_DATA(IDLE_DATA)
  ) dut (
    .clk(clk), .sys_rst(rst), .src_oe(src_oe), .src_do(src_do),
    .bus_do(bus_do), .dat_dir(dat_dir), .dat_oe(dat_oe), .busy(busy),
    .active_ch(active_ch), .coll_flag(coll_flag), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [CHANNELS-1:0] v);
    for (int i = 0; i < CHANNELS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Model: m_dir = direction out, m_drv = enabled, m_rel = winding down; m_age counts
  // cycles spent in the current setup or release window.
  logic          m_dir = 1'b0, m_drv = 1'b0, m_rel = 1'b0;
  int            m_age = 0;
  logic [DW-1:0] m_bus = IDLE_DATA;
  logic [CW-1:0] m_ch = '0;
  logic          m_flag = 1'b0;
  logic [15:0]   m_cnt = 16'h0;
  logic [CHANNELS-1:0] m_prev = '0;
  logic          any_tb;
  assign any_tb = |src_oe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dir <= 1'b0; m_drv <= 1'b0; m_rel <= 1'b0; m_age <= 0;
      m_bus <= IDLE_DATA; m_ch <= '0;
      m_flag <= 1'b0; m_cnt <= 16'h0; m_prev <= '0;
    end else begin
      if (!m_dir) begin
        if (any_tb) begin m_dir <= 1'b1; m_age <= 1; end
      end else if (m_drv) begin
        if (!any_tb) begin m_drv <= 1'b0; m_rel <= 1'b1; m_age <= 1; end
      end else if (m_rel) begin
        if (any_tb) begin m_rel <= 1'b0; m_drv <= 1'b1; end
        else if (m_age >= REL_HOLD + 1) begin m_dir <= 1'b0; m_rel <= 1'b0; end
        else m_age <= m_age + 1;
      end else begin
        if (!any_tb) begin m_rel <= 1'b1; m_age <= 1; end
        else if (m_age >= DIR_SETUP) m_drv <= 1'b1;
        else m_age <= m_age + 1;
      end
      if (any_tb) begin
        m_bus <= src_do[first_set(src_oe)*DW +: DW];
        m_ch  <= CW'(first_set(src_oe));
      end else if (!m_dir) begin
        m_bus <= IDLE_DATA;
      end
`ifdef CART_BUS_COLL_EN
      m_prev <= src_oe;
      if (m_drv && ($countones(src_oe) > 1) && (src_oe != m_prev)) begin
        m_flag <= 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end else begin
        m_flag <= 1'b0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    chk("dat_dir", 32'(dat_dir), 32'(m_dir));
    chk("dat_oe", 32'(dat_oe), 32'(!m_drv));
    chk("busy", 32'(busy), 32'(m_dir));
    chk("bus_do", 32'(bus_do), 32'(m_bus));
    chk("active_ch", 32'(active_ch), 32'(m_ch));
    chk("coll_flag", 32'(coll_flag), 32'(m_flag));
    chk("coll_cnt", 32'(coll_cnt), 32'(m_cnt));
    if (!dat_oe) chk("oe_implies_dir", 32'(dat_dir), 32'd1);
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [CHANNELS-1:0] seq [16] = '{8'h80, 8'h80, 8'h80, 8'h40, 8'h60, 8'h00, 8'h20, 8'h00,
                                     8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

  initial begin
    rst    = 1'b1;
    src_oe = '0;
    for (int i = 0; i < CHANNELS; i++) src_do[i*DW +: DW] = 16'(16'h1000 + i * 16'h0101);
    src_do[2*DW +: DW] = 16'hA5C3;
    tick(2);
    chk("rst_dat_oe", 32'(dat_oe), 32'd1);
    chk("rst_bus_do", 32'(bus_do), 32'h0000);
    rst = 1'b0;
    tick(1);

    // Single source with default timing.
    src_oe = 8'b0000_0100;
    tick(1);
    chk("s2_dir_e1", 32'(dat_dir), 32'd1);
    chk("s2_oe_e1", 32'(dat_oe), 32'd1);
    tick(1);
    chk("s2_oe_e2", 32'(dat_oe), 32'd1);
    tick(1);
    chk("s2_oe_e3", 32'(dat_oe), 32'd0);
    chk("s2_bus", 32'(bus_do), 32'hA5C3);
    chk("s2_ch", 32'(active_ch), 32'd2);
    tick(7);
    src_oe = '0;
    tick(1);
    chk("s2_rel_oe", 32'(dat_oe), 32'd1);
    chk("s2_rel_dir", 32'(dat_dir), 32'd1);
    tick(2);
    chk("s2_idle_dir", 32'(dat_dir), 32'd0);
    chk("s2_hold_bus", 32'(bus_do), 32'hA5C3);
    tick(1);
    chk("s2_idle_bus", 32'(bus_do), 32'h0000);

    // Priority change inside DRIVE.
    src_oe = 8'b1001_0000;
    tick(3);
    chk("pri_ch4", 32'(active_ch), 32'd4);
    chk("pri_bus4", 32'(bus_do), 32'h1404);
    chk("pri_oe4", 32'(dat_oe), 32'd0);
    src_oe = 8'b1001_0001;
    tick(1);
    chk("pri_ch0", 32'(active_ch), 32'd0);
    chk("pri_bus0", 32'(bus_do), 32'h1000);
    chk("pri_oe0", 32'(dat_oe), 32'd0);
    src_oe = '0;
    tick(5);

    // One-cycle request aborts from SETUP without enabling.
    src_oe = 8'b0000_0010;
    tick(1);
    src_oe = '0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_oe", 32'(dat_oe), 32'd1);
      tick(1);
    end
    chk("abort_dir", 32'(dat_dir), 32'd0);

    // Re-request during RELEASE goes straight back to DRIVE.
    src_oe = 8'b0010_0000;
    tick(3);
    chk("rr_drive", 32'(dat_oe), 32'd0);
    src_oe = '0;
    tick(1);
    chk("rr_rel_oe", 32'(dat_oe), 32'd1);
    src_oe = 8'b0010_0000;
    tick(1);
    chk("rr_redrive_oe", 32'(dat_oe), 32'd0);
    chk("rr_dir", 32'(dat_dir), 32'd1);
    src_oe = '0;
    tick(4);

`ifdef CART_BUS_COLL_EN
    src_oe = 8'b01;
    tick(3);
    src_oe = 8'b11;
    tick(1);
    chk("coll_flag1", 32'(coll_flag), 32'd1);
    tick(4);
    chk("coll_flag_held", 32'(coll_flag), 32'd0);
    src_oe = 8'b01;
    tick(1);
    src_oe = 8'b11;
    tick(1);
    chk("coll_flag2", 32'(coll_flag), 32'd1);
    chk("coll_cnt2", 32'(coll_cnt), 32'd2);
    src_oe = '0;
    tick(4);
`endif

    // Mixed pattern table, checked entirely by the model.
    for (int k = 0; k < 16; k++) begin
      src_oe = seq[k];
      tick(1);
    end
    tick(3);

    // Reset in the middle of DRIVE.
    src_oe = 8'b0000_1000;
    tick(3);
    chk("mr_pre_oe", 32'(dat_oe), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mr_oe", 32'(dat_oe), 32'd1);
    chk("mr_dir", 32'(dat_dir), 32'd0);
    chk("mr_bus", 32'(bus_do), 32'h0000);
    chk("mr_ch", 32'(active_ch), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mr_setup_dir", 32'(dat_dir), 32'd1);
    chk("mr_setup_oe", 32'(dat_oe), 32'd1);
    chk("mr_setup_busy", 32'(busy), 32'd1);
    src_oe = '0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
